// File: rtl/median_rank.sv
// median_rank: rank-order filter for pixel windows.
// Captures a burst of N samples into a shift chain. It then runs repeated
// max-extraction passes over the chain to find the RANK-th largest sample
// (0 = max, (N-1)/2 = median, N-1 = min).
module median_rank #(
  parameter  int WIDTH = 8,
  parameter  int N     = 9,
  localparam int RW    = $clog2(N)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DSI,
  input  logic [WIDTH-1:0] DI,
  input  logic [RW-1:0]    RANK,
  output logic [WIDTH-1:0] DO,
  output logic             DSO,
  output logic             BUSY,
  output logic             ERR
);

  // The counter must be able to hold N itself during load, so it gets one extra code.
  localparam int CW = $clog2(N + 1);

  localparam logic [CW-1:0] N_C    = CW'(N);
  localparam logic [CW-1:0] LAST_C = CW'(N - 1);
  localparam logic [RW-1:0] MAX_RK = RW'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMP, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    pass_q, pass_d;
  logic [RW-1:0]    rk_q, rk_d;
  logic [WIDTH-1:0] mx_q, mx_d;
  logic [WIDTH-1:0] do_q, do_d;
  logic             err_q, err_d;
  logic             dsi_prev_q, dsi_prev_d;
  logic [WIDTH-1:0] chain_q [N];
  logic [WIDTH-1:0] chain_d [N];

  logic             shift_en;
  logic [WIDTH-1:0] shift_in;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] winner;
  logic [RW-1:0]    rank_clamped;
  logic             start;

  // The chain head feeds the comparator. A new window starts only on a DSI rising
  // edge, so a burst that began while busy is never picked up halfway through.
  always_comb begin
    head         = chain_q[0];
    winner       = (head > mx_q) ? head : mx_q;
    rank_clamped = (RANK > MAX_RK) ? MAX_RK : RANK;
    start        = DSI && !dsi_prev_q;
  end

  // State register and control/result flops.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pass_q  <= '0;
      rk_q    <= '0;
      mx_q    <= '0;
      do_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      rk_q    <= rk_d;
      mx_q    <= mx_d;
      do_q    <= do_d;
      err_q   <= err_d;
    end
  end

  // The DSI history keeps tracking the pin through reset. This means a burst that
  // is still in flight when reset releases is not mistaken for a new one.
  always_ff @(posedge CLK) begin
    dsi_prev_q <= dsi_prev_d;
  end

  // The sample chain has no reset: every window overwrites all N entries before use.
  always_ff @(posedge CLK) begin
    chain_q <= chain_d;
  end

  // Next-state logic for the window FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!DSI) begin
          state_d = (cnt_q < N_C) ? IDLE : COMP;
        end
      end
      COMP: begin
        if (cnt_q == LAST_C && pass_q == rk_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath control covers sample loading, burst-length check and the extraction passes.
  // Each extraction cycle pops the chain head and pushes one value back in.
  // Cycle 0 of a pass pushes a zero in place of the value it took into MX.
  // Zero can never beat a real sample under unsigned compare. These zero
  // fillers therefore never change the max that a later pass finds.
  always_comb begin
    cnt_d      = cnt_q;
    pass_d     = pass_q;
    rk_d       = rk_q;
    mx_d       = mx_q;
    do_d       = do_q;
    err_d      = 1'b0;
    dsi_prev_d = DSI;
    shift_en   = 1'b0;
    shift_in   = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_en = 1'b1;
          shift_in = DI;
          cnt_d    = CW'(1);
        end
      end
      LOAD: begin
        if (DSI) begin
          shift_en = 1'b1;
          shift_in = DI;
          if (cnt_q < N_C) begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (cnt_q < N_C) begin
          err_d = 1'b1;
          cnt_d = '0;
        end else begin
          rk_d   = rank_clamped;
          cnt_d  = '0;
          pass_d = '0;
        end
      end
      COMP: begin
        shift_en = 1'b1;
        if (cnt_q == '0) begin
          mx_d     = head;
          shift_in = '0;
        end else begin
          mx_d     = winner;
          shift_in = (head > mx_q) ? mx_q : head;
        end
        if (cnt_q == LAST_C) begin
          cnt_d = '0;
          if (pass_q == rk_q) begin
            do_d = winner;
          end else begin
            pass_d = pass_q + RW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        cnt_d  = '0;
        pass_d = '0;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Shift chain: entries move toward the head and new values enter at the tail.
  always_comb begin
    for (int i = 0; i < N - 1; i++) begin
      chain_d[i] = shift_en ? chain_q[i+1] : chain_q[i];
    end
    chain_d[N-1] = shift_en ? shift_in : chain_q[N-1];
  end

  // Output decode from the current state.
  always_comb begin
    BUSY = 1'b0;
    DSO  = 1'b0;
    case (state_q)
      COMP: begin
        BUSY = 1'b1;
      end
      DONE: begin
        BUSY = 1'b1;
        DSO  = 1'b1;
      end
      default: begin
        BUSY = 1'b0;
      end
    endcase
  end

  assign DO  = do_q;
  assign ERR = err_q;

endmodule

// File: tb/tb_median_rank.sv
// Directed testbench for median_rank with N=9 and WIDTH=8.
// Expected results come from hand-sorted windows.
module tb_median_rank;

  logic       CLK;
  logic       RST;
  logic       DSI;
  logic [7:0] DI;
  logic [3:0] RANK;
  logic [7:0] DO;
  logic       DSO;
  logic       BUSY;
  logic       ERR;

  int checks;
  int errors;
  int dsoSeen;
  int errSeen;

  int w1[$]     = {9, 8, 7, 6, 5, 4, 3, 2, 1};
  int wSame[$]  = {7, 7, 7, 7, 7, 7, 7, 7, 7};
  int wAlt[$]   = {255, 0, 255, 0, 255, 0, 255, 0, 128};
  int wShort[$] = {50, 60, 70, 80, 90};
  int wLong[$]  = {200, 201, 9, 8, 7, 6, 5, 4, 3, 2, 1};
  int w100[$]   = {100, 100, 100, 100, 100, 100, 100, 100, 100};

  median_rank #(.WIDTH(8), .N(9)) dut (
    .CLK (CLK),
    .RST (RST),
    .DSI (DSI),
    .DI  (DI),
    .RANK(RANK),
    .DO  (DO),
    .DSO (DSO),
    .BUSY(BUSY),
    .ERR (ERR)
  );

  // 10 ns clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard stop in case a wait slips past its own bound
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count DSO/ERR pulses seen on each sampled negedge
  task automatic watch();
    if (DSO === 1'b1) dsoSeen++;
    if (ERR === 1'b1) errSeen++;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      watch();
    end
  endtask

  // Drives one burst starting at the current negedge and leaves DSI low at the end
  task automatic applyStimulus(input int q[$]);
    foreach (q[i]) begin
      DSI = 1'b1;
      DI  = 8'(q[i]);
      @(negedge CLK);
      watch();
    end
    DSI = 1'b0;
    DI  = 8'h00;
  endtask

  // Full window: burst, latency, BUSY profile, result and DSO pulse width.
  // RANK is changed mid-computation to show that only the value at t0 matters.
  task automatic runWindow(input string tag, input int q[$], input int rank,
                           input int expVal, input int lat);
    int  cyc;
    bit  busyOk;
    RANK = 4'(rank);
    applyStimulus(q);
    cyc    = 0;
    busyOk = 1'b1;
    do begin
      @(negedge CLK);
      cyc++;
      if (cyc == 2) RANK = 4'(rank ^ 1);
      if (DSO !== 1'b1 && BUSY !== 1'b1) busyOk = 1'b0;
    end while (DSO !== 1'b1 && cyc < 200);
    checkOutput({tag, "_latency"}, cyc - 1, lat);
    checkOutput({tag, "_busy_held"}, 32'(busyOk), 1);
    checkOutput({tag, "_do"}, DO, expVal);
    checkOutput({tag, "_busy_at_dso"}, BUSY, 1);
    @(negedge CLK);
    checkOutput({tag, "_dso_one_cycle"}, DSO, 0);
    checkOutput({tag, "_busy_fall"}, BUSY, 0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    dsoSeen = 0;
    errSeen = 0;
    RST     = 1'b1;
    DSI     = 1'b0;
    DI      = 8'h00;
    RANK    = 4'd0;

    // Reset values
    repeat (3) @(negedge CLK);
    checkOutput("reset_do", DO, 0);
    checkOutput("reset_dso", DSO, 0);
    checkOutput("reset_busy", BUSY, 0);
    checkOutput("reset_err", ERR, 0);
    RST = 1'b0;
    @(negedge CLK);

    // Median, max, min and clamped rank on a descending window
    runWindow("median", w1, 4, 5, 45);
    runWindow("max", w1, 0, 9, 9);
    runWindow("min", w1, 8, 1, 81);
    runWindow("clamp15", w1, 15, 1, 81);

    // All-equal and extreme-value windows
    runWindow("equal", wSame, 4, 7, 45);
    runWindow("alt", wAlt, 4, 128, 45);

    // Short burst: ERR at t0, nothing else happens, DO keeps 128
    idleCycles(2);
    RANK = 4'd4;
    applyStimulus(wShort);
    @(negedge CLK);
    checkOutput("short_err", ERR, 1);
    checkOutput("short_busy", BUSY, 0);
    dsoSeen = 0;
    errSeen = 0;
    idleCycles(30);
    checkOutput("short_no_dso", dsoSeen, 0);
    checkOutput("short_err_once", errSeen, 0);
    checkOutput("short_do_kept", DO, 128);

    // Long burst: only the last nine samples count (first nine would give 7)
    runWindow("long", wLong, 4, 5, 45);

    // A burst during COMP is dropped with no ERR and no second result
    idleCycles(2);
    dsoSeen = 0;
    errSeen = 0;
    RANK    = 4'd4;
    applyStimulus(w1);
    idleCycles(5);
    applyStimulus(w100);
    idleCycles(60);
    checkOutput("busyburst_dso_count", dsoSeen, 1);
    checkOutput("busyburst_err_count", errSeen, 0);
    checkOutput("busyburst_do", DO, 5);

    // A burst that starts in COMP and runs past BUSY falling is still dropped
    dsoSeen = 0;
    errSeen = 0;
    RANK    = 4'd0;
    applyStimulus(w1);
    idleCycles(4);
    applyStimulus(w100);
    idleCycles(30);
    checkOutput("straddle_dso_count", dsoSeen, 1);
    checkOutput("straddle_err_count", errSeen, 0);
    checkOutput("straddle_do", DO, 9);

    // Reset at t0+20 aborts the computation
    idleCycles(2);
    RANK = 4'd4;
    applyStimulus(w1);
    idleCycles(20);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    checkOutput("abort_dso", DSO, 0);
    checkOutput("abort_busy", BUSY, 0);
    checkOutput("abort_do", DO, 0);
    checkOutput("abort_err", ERR, 0);
    dsoSeen = 0;
    errSeen = 0;
    idleCycles(50);
    checkOutput("abort_no_dso", dsoSeen, 0);
    checkOutput("abort_no_err", errSeen, 0);

    // Recovery, then a back-to-back window with the minimum gap
    runWindow("recover", w1, 4, 5, 45);
    runWindow("backtoback", wAlt, 0, 255, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
